// File: rtl/fetch_pc_gen_if.sv
// Predictor, PC-file and fetch-block bus between fetch_pc_gen and its neighbours.
// slave = the PC generator, master = the predictor/backend/fetch side driving it.
interface fetch_pc_gen_if #(
    parameter int FETCH_SLOTS = 8,
    parameter int FID_W       = 5,
    parameter int HIST_W      = 16,
    parameter int BPI_W       = 4
);
    localparam int S = $clog2(FETCH_SLOTS);

    logic                          IN_en;
    logic                          IN_redirValid;
    logic [31:0]                   IN_redirPc;
    logic [FID_W-1:0]              IN_redirFetchID;
    logic                          IN_bpFound;
    logic                          IN_bpTaken;
    logic                          IN_bpIsJump;
    logic                          IN_bpMultiple;
    logic [31:0]                   IN_bpSrc;
    logic [31:0]                   IN_bpDst;
    logic [HIST_W-1:0]             IN_bpHist;
    logic [BPI_W-1:0]              IN_bpInfo;
    logic [FID_W-1:0]              IN_robFetchID;
    logic [31:0]                   OUT_pc;
    logic                          OUT_stall;
    logic                          OUT_pcfWe;
    logic [FID_W-1:0]              OUT_pcfAddr;
    logic [31+HIST_W+BPI_W+S-1:0]  OUT_pcfData;
    logic                          OUT_valid;
    logic                          IN_ready;
    logic [31:0]                   OUT_blkPc;
    logic [FID_W-1:0]              OUT_blkFetchID;
    logic [FETCH_SLOTS-1:0]        OUT_slotValid;
    logic [FETCH_SLOTS-1:0]        OUT_slotPredTaken;

    modport master (
        output IN_en, IN_redirValid, IN_redirPc, IN_redirFetchID, IN_bpFound, IN_bpTaken,
               IN_bpIsJump, IN_bpMultiple, IN_bpSrc, IN_bpDst, IN_bpHist, IN_bpInfo,
               IN_robFetchID, IN_ready,
        input  OUT_pc, OUT_stall, OUT_pcfWe, OUT_pcfAddr, OUT_pcfData, OUT_valid,
               OUT_blkPc, OUT_blkFetchID, OUT_slotValid, OUT_slotPredTaken
    );

    modport slave (
        input  IN_en, IN_redirValid, IN_redirPc, IN_redirFetchID, IN_bpFound, IN_bpTaken,
               IN_bpIsJump, IN_bpMultiple, IN_bpSrc, IN_bpDst, IN_bpHist, IN_bpInfo,
               IN_robFetchID, IN_ready,
        output OUT_pc, OUT_stall, OUT_pcfWe, OUT_pcfAddr, OUT_pcfData, OUT_valid,
               OUT_blkPc, OUT_blkFetchID, OUT_slotValid, OUT_slotPredTaken
    );
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch-block PC/ID generator with a FETCH_Q_DEPTH block queue; push to head visible next cycle.
// Stalls on full queue or fetch-ID collision with the ROB; FETCH_PC_GEN_FULL_PASS_EN lets a full queue push on a pop.
module fetch_pc_gen #(
    parameter int          FETCH_SLOTS   = 8,
    parameter int          FETCH_Q_DEPTH = 4,
    parameter int          FID_W         = 5,
    parameter int          HIST_W        = 16,
    parameter int          BPI_W         = 4,
    parameter logic [31:0] RESET_PC      = 32'h80000000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_pc_gen_if.slave bus
);
    localparam int S  = $clog2(FETCH_SLOTS);
    localparam int QW = $clog2(FETCH_Q_DEPTH);
    localparam int CW = QW + 1;

    typedef struct packed {
        logic [30:0]            pc;
        logic [FID_W-1:0]       fid;
        logic [FETCH_SLOTS-1:0] slot_v;
        logic [FETCH_SLOTS-1:0] slot_t;
    } entry_t;

    entry_t           q_mem [FETCH_Q_DEPTH];
    logic [30:0]      pc_q;
    logic [FID_W-1:0] fid_q;
    logic [CW-1:0]    count_q;
    logic [QW-1:0]    rd_q, wr_q;

    logic                   valid, pop, push, full, id_stall, stall, tk, cut;
    logic [S-1:0]           bp, start;
    logic [FETCH_SLOTS-1:0] slot_v, slot_t;
    logic [30:0]            next_pc;
    entry_t                 head;
    logic                   unused_ok;

    assign unused_ok = ^{bus.IN_redirPc[0], bus.IN_bpSrc[0], bus.IN_bpDst[0]};

    assign valid    = (count_q != '0);
    assign pop      = valid & bus.IN_ready;
    assign id_stall = (fid_q == bus.IN_robFetchID);
`ifdef FETCH_PC_GEN_FULL_PASS_EN
    assign full     = (count_q == CW'(FETCH_Q_DEPTH)) & ~pop;
`else
    assign full     = (count_q == CW'(FETCH_Q_DEPTH));
`endif
    assign stall    = id_stall | full;
    assign push     = bus.IN_en & ~stall & ~bus.IN_redirValid & ~rst;

    assign bp    = bus.IN_bpSrc[S:1];
    assign start = pc_q[S-1:0];
    assign tk    = bus.IN_bpFound & (bus.IN_bpIsJump | bus.IN_bpTaken);
    // A not-taken branch followed by another one ends the block at the found branch.
    assign cut   = tk | (bus.IN_bpFound & bus.IN_bpMultiple);

    always_comb begin
        slot_v = '0;
        slot_t = '0;
        for (int i = 0; i < FETCH_SLOTS; i++) begin
            slot_v[i] = (S'(i) >= start) && (!cut || S'(i) <= bp);
            slot_t[i] = tk && (S'(i) == bp);
        end
    end

    always_comb begin
        next_pc = {pc_q[30:S] + (31-S)'(1), {S{1'b0}}};
        if (tk)
            next_pc = bus.IN_bpDst[31:1];
        else if (cut)
            next_pc = bus.IN_bpSrc[31:1] + 31'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC[31:1];
            fid_q   <= '0;
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else if (bus.IN_redirValid) begin
            pc_q    <= bus.IN_redirPc[31:1];
            fid_q   <= bus.IN_redirFetchID + FID_W'(1);
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            if (push) begin
                pc_q  <= next_pc;
                fid_q <= fid_q + FID_W'(1);
                wr_q  <= wr_q + QW'(1);
            end
            if (pop)
                rd_q <= rd_q + QW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: head outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push)
            q_mem[wr_q] <= '{pc: pc_q, fid: fid_q, slot_v: slot_v, slot_t: slot_t};
    end

    assign head = q_mem[rd_q];

    assign bus.OUT_pc            = {pc_q, 1'b0};
    assign bus.OUT_stall         = stall;
    assign bus.OUT_pcfWe         = push;
    assign bus.OUT_pcfAddr       = fid_q;
    assign bus.OUT_pcfData       = {pc_q, bus.IN_bpHist, bus.IN_bpInfo, bp};
    assign bus.OUT_valid         = valid;
    assign bus.OUT_blkPc         = valid ? {head.pc, 1'b0} : 32'd0;
    assign bus.OUT_blkFetchID    = valid ? head.fid : '0;
    assign bus.OUT_slotValid     = valid ? head.slot_v : '0;
    assign bus.OUT_slotPredTaken = valid ? head.slot_t : '0;
endmodule
